// File: rtl/output_shaper.sv
// output_shaper: tick-gated discrete output driver with minimum level dwell,
// programmable polarity and single timed pulses under a busy handshake.
module output_shaper #(
  parameter int SYS_CLOCK   = 72_000_000,
  parameter int POLL_CLOCK  = 100_000,
  parameter int MIN_TICKS   = 16,
  parameter int PULSE_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   sclr,
  input  logic                   req,
  input  logic                   level,
  input  logic                   pulse_start,
  input  logic [PULSE_WIDTH-1:0] pulse_len,
  output logic                   pulse_busy,
  output logic                   out,
  output logic                   state,
  output logic                   pending
);
  function automatic int get_width(input int v);
    return (v < 2) ? 1 : $clog2(v + 1);
  endfunction
  localparam int MAX = SYS_CLOCK / POLL_CLOCK - 1;
  localparam int CW  = get_width(MAX);
  localparam int DW  = get_width(MIN_TICKS);
  localparam logic [CW-1:0] C_MAX  = CW'(MAX);
  localparam logic [DW-1:0] D_MAX  = DW'(MIN_TICKS);
  localparam logic [DW-1:0] D_LAST = DW'(MIN_TICKS - 1);
  localparam logic [PULSE_WIDTH-1:0] P_ONE = PULSE_WIDTH'(1);
  typedef enum logic [1:0] {S_IDLE, S_PWAIT, S_PULSE} fsm_t;
  fsm_t                   r_fsm, w_fsm;
  logic [CW-1:0]          r_cnt;
  logic [DW-1:0]          r_dwell;
  logic [PULSE_WIDTH-1:0] r_pcnt, w_pcnt;
  logic                   r_l, w_l, r_busy, w_busy;
  logic                   w_tick, w_settled, w_change;
  assign w_tick    = r_cnt == C_MAX;
  // the tick being evaluated counts toward the dwell, so a level may move on its MIN_TICKS-th tick
  assign w_settled = (r_dwell == D_MAX) || (w_tick && r_dwell == D_LAST);
  assign w_change  = w_l != r_l;
  always_comb begin
    w_fsm  = r_fsm;
    w_l    = r_l;
    w_busy = r_busy;
    w_pcnt = r_pcnt;
    case (r_fsm)
      S_IDLE: begin
        if (w_tick && w_settled) w_l = req;
        if (pulse_start && pulse_len != '0) begin
          w_fsm  = S_PWAIT;
          w_busy = 1'b1;
          w_pcnt = pulse_len;
        end
      end
      S_PWAIT: begin
        if (w_tick && w_settled) begin
          w_l = ~r_l;
          if (!r_l) begin
            w_fsm  = S_PULSE;
            w_pcnt = r_pcnt - P_ONE;
          end
        end
      end
      S_PULSE: begin
        if (w_tick) begin
          w_pcnt = r_pcnt - P_ONE;
          if (r_pcnt <= P_ONE) begin
            w_l    = 1'b0;
            w_busy = 1'b0;
            w_fsm  = S_IDLE;
            w_pcnt = '0;
          end
        end
      end
      default: w_fsm = S_IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (sclr) begin
      r_cnt   <= '0;
      r_dwell <= D_MAX;
      r_fsm   <= S_IDLE;
      r_l     <= 1'b0;
      r_busy  <= 1'b0;
      r_pcnt  <= '0;
      out     <= 1'b0;
    end else begin
      r_cnt   <= w_tick ? '0 : r_cnt + 1'b1;
      r_dwell <= w_change ? '0 : (w_tick && r_dwell != D_MAX) ? r_dwell + 1'b1 : r_dwell;
      r_fsm   <= w_fsm;
      r_l     <= w_l;
      r_busy  <= w_busy;
      r_pcnt  <= w_pcnt;
      out     <= r_l ^ level;
    end
  end
  assign pulse_busy = r_busy;
  assign state      = r_l;
  assign pending    = (req != r_l) && !r_busy;
endmodule

// File: tb/tb_output_shaper.sv
// tb_output_shaper: directed stimulus, tick-level behavioural model checked every cycle,
// plus hand-computed expectations at key cycles.
module tb_output_shaper;
  localparam int MIN_T = 3;
  logic       clk = 1'b0, sclr = 1'b1, req = 1'b0, level = 1'b0, pulse_start = 1'b0;
  logic [7:0] pulse_len = 8'd0;
  logic       pulse_busy, out, state, pending;
  int         total = 0, bad = 0;
  int         cyc = 0, m_held = MIN_T, m_ev = 0;
  logic       m_l = 1'b0, m_busy = 1'b0, m_high = 1'b0, m_out = 1'b0, chk_en = 1'b0;
  logic [7:0] m_len = 8'd0;
  logic       m_tick, m_ok;

  output_shaper #(.SYS_CLOCK(1000), .POLL_CLOCK(100), .MIN_TICKS(MIN_T), .PULSE_WIDTH(8)) dut (
    .clock(clk), .sclr(sclr), .req(req), .level(level), .pulse_start(pulse_start),
    .pulse_len(pulse_len), .pulse_busy(pulse_busy), .out(out), .state(state), .pending(pending)
  );

  always #5 clk = ~clk;

  // model works in whole poll ticks: tick every 10th cycle, held = ticks since last level change
  assign m_tick = (cyc % 10) == 9;
  assign m_ok   = m_held + 1 >= MIN_T;

  always @(posedge clk) begin
    if (sclr) begin
      cyc <= 0; m_l <= 1'b0; m_held <= MIN_T; m_busy <= 1'b0; m_high <= 1'b0;
      m_ev <= 0; m_len <= 8'd0; m_out <= 1'b0;
    end else begin
      cyc   <= cyc + 1;
      m_out <= m_l ^ level;
      if (m_tick) m_held <= (m_held + 1 > MIN_T) ? MIN_T : m_held + 1;
      if (!m_busy) begin
        if (m_tick && req != m_l && m_ok) begin
          m_l <= req; m_held <= 0;
        end
        if (pulse_start && pulse_len != 8'd0) begin
          m_busy <= 1'b1; m_len <= pulse_len; m_high <= 1'b0;
        end
      end else if (m_tick) begin
        if (!m_high && m_ok) begin
          m_l <= ~m_l; m_held <= 0;
          if (!m_l) begin m_high <= 1'b1; m_ev <= 1; end
        end else if (m_high) begin
          if (m_ev + 1 >= ((m_len < 8'd2) ? 2 : int'(m_len))) begin
            m_l <= 1'b0; m_held <= 0; m_busy <= 1'b0; m_high <= 1'b0;
          end else m_ev <= m_ev + 1;
        end
      end
    end
  end

  task automatic check(input string name, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0b expected %0b", name, cyc, got, exp);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    check("out", out, m_out);
    check("state", state, m_l);
    check("pulse_busy", pulse_busy, m_busy);
    check("pending", pending, (req != m_l) && !m_busy);
  end

  task automatic do_reset();
    @(posedge clk); #2;
    sclr = 1'b1; req = 1'b0; level = 1'b0; pulse_start = 1'b0; pulse_len = 8'd0;
    @(posedge clk); #2;
    sclr = 1'b0; chk_en = 1'b1;
  endtask

  task automatic go(input int n);
    while (cyc < n) begin @(posedge clk); #2; end
  endtask

  task automatic at(input int n);
    go(n); #3;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // follow with dwell, then polarity
    do_reset();
    req = 1'b1;
    at(9);  check("A_state9", state, 1'b0);
    at(10); check("A_state10", state, 1'b1); check("A_out10", out, 1'b0);
    at(11); check("A_out11", out, 1'b1);
    go(12); req = 1'b0; #3; check("A_pending12", pending, 1'b1);
    at(39); check("A_state39", state, 1'b1);
    at(40); check("A_state40", state, 1'b0); check("A_out40", out, 1'b1);
    at(41); check("A_out41", out, 1'b0);
    go(45); level = 1'b1;
    at(47); check("P_out47", out, 1'b1);
    go(50); level = 1'b0; #3; check("P_out50", out, 1'b1);
    at(51); check("P_out51", out, 1'b0); check("P_state51", state, 1'b0);
    // glitch rejection
    do_reset();
    go(12); req = 1'b1;
    at(14); check("G_pending14", pending, 1'b1);
    go(17); req = 1'b0; #3; check("G_pending17", pending, 1'b0);
    at(20); check("G_state20", state, 1'b0);
    at(21); check("G_out21", out, 1'b0);
    // pulse from settled low
    do_reset();
    go(100); pulse_start = 1'b1; pulse_len = 8'd5; #3; check("C_busy100", pulse_busy, 1'b0);
    go(101); pulse_start = 1'b0; req = 1'b1; #3; check("C_busy101", pulse_busy, 1'b1);
    check("C_pending101", pending, 1'b0);
    at(109); check("C_state109", state, 1'b0);
    at(110); check("C_state110", state, 1'b1);
    go(120); pulse_start = 1'b1; pulse_len = 8'd9;
    go(121); pulse_start = 1'b0;
    at(149); check("C_state149", state, 1'b1); check("C_busy149", pulse_busy, 1'b1);
    at(150); check("C_state150", state, 1'b0); check("C_busy150", pulse_busy, 1'b0);
    check("C_pending150", pending, 1'b1);
    at(179); check("C_state179", state, 1'b0);
    at(180); check("C_state180", state, 1'b1);
    // zero length, then pulse from settled high
    do_reset();
    req = 1'b1;
    go(20); pulse_start = 1'b1; pulse_len = 8'd0;
    go(21); pulse_start = 1'b0; #3; check("D_busy21", pulse_busy, 1'b0);
    go(40); pulse_start = 1'b1; pulse_len = 8'd2;
    go(41); pulse_start = 1'b0; #3; check("D_busy41", pulse_busy, 1'b1);
    at(49); check("D_state49", state, 1'b1);
    at(50); check("D_state50", state, 1'b0);
    at(79); check("D_state79", state, 1'b0);
    at(80); check("D_state80", state, 1'b1);
    at(89); check("D_state89", state, 1'b1); check("D_busy89", pulse_busy, 1'b1);
    at(90); check("D_state90", state, 1'b0); check("D_busy90", pulse_busy, 1'b0);
    at(119); check("D_state119", state, 1'b0);
    at(120); check("D_state120", state, 1'b1);
    // reset in the middle of an 8-tick pulse
    do_reset();
    pulse_start = 1'b1; pulse_len = 8'd8;
    go(1); pulse_start = 1'b0;
    at(29); check("E_out29", out, 1'b1); check("E_busy29", pulse_busy, 1'b1);
    go(30); sclr = 1'b1; req = 1'b1;
    @(posedge clk); #2; sclr = 1'b0; #3;
    check("E_out_rst", out, 1'b0); check("E_state_rst", state, 1'b0);
    check("E_busy_rst", pulse_busy, 1'b0);
    at(9);  check("E_state9", state, 1'b0);
    at(10); check("E_state10", state, 1'b1);
    at(15);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
